// File: rtl/lego_sa_ctrl.sv
// Tile sequencer for the Lego systolic array: weight load, activation streaming
// and output drain for one tile command at a time, with a drain watchdog.
module lego_sa_ctrl #(
  parameter int ARRAY_DIM = 32,
  parameter int LEN_W     = 10,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_mode,
  input  logic [LEN_W-1:0]             cmd_len,
  input  logic                         cmd_skip_w,
  output logic                         w_rd_en,
  output logic [$clog2(ARRAY_DIM)-1:0] w_rd_addr,
  output logic                         sa_load_w,
  output logic                         act_rd_en,
  output logic [LEN_W-1:0]             act_rd_addr,
  output logic                         sa_valid_in,
  output logic [1:0]                   sa_type,
  input  logic                         sa_valid_out,
  output logic                         out_wr_en,
  output logic [LEN_W-1:0]             out_wr_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout
);

  localparam int AW = $clog2(ARRAY_DIM);
  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]    W_LAST  = AW'(ARRAY_DIM - 1);
  localparam logic [DW-1:0]    TO_LAST = DW'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    w_cnt;
  logic [LEN_W-1:0] act_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       type_q;
  logic             err_q;
  logic             load_w_p1;
  logic             vld_p1;
  logic             accept;
  logic             timeout_hit;

  assign accept      = (state_q == IDLE) && cmd_valid;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign w_rd_en     = (state_q == WLOAD);
  assign w_rd_addr   = w_cnt;
  assign act_rd_en   = (state_q == STREAM);
  assign act_rd_addr = act_cnt;
  assign sa_load_w   = load_w_p1;
  assign sa_valid_in = vld_p1;
  assign sa_type     = type_q;
  assign out_wr_en   = sa_valid_out && ((state_q == STREAM) || (state_q == DRAIN));
  assign out_wr_addr = out_cnt;
  assign err_timeout = err_q;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_skip_w)          state_d = WLOAD;
          else if (cmd_len != '0)   state_d = STREAM;
          else                      state_d = DONE;
        end
      end
      WLOAD: begin
        if (w_cnt == W_LAST) state_d = (len_q != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (act_cnt == len_q - LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Completion wins over the watchdog when both land in the same cycle.
        if (out_cnt == len_q) begin
          state_d = DONE;
        end else if (drain_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_cnt     <= '0;
      act_cnt   <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      len_q     <= '0;
      type_q    <= '0;
      err_q     <= 1'b0;
      load_w_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p1: buffer read latency, strobes reach the array one cycle later
      load_w_p1 <= w_rd_en;
      vld_p1    <= act_rd_en;
      if (accept) begin
        type_q    <= cmd_mode;
        len_q     <= cmd_len;
        err_q     <= 1'b0;
        w_cnt     <= '0;
        act_cnt   <= '0;
        out_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (w_rd_en && (w_cnt != W_LAST))     w_cnt     <= w_cnt + AW'(1);
        if (act_rd_en && (act_cnt != CNT_MAX)) act_cnt  <= act_cnt + LEN_W'(1);
        if (out_wr_en && (out_cnt != CNT_MAX)) out_cnt  <= out_cnt + LEN_W'(1);
        if ((state_q == DRAIN) && !timeout_hit) drain_cnt <= drain_cnt + DW'(1);
        if (timeout_hit)                      err_q     <= 1'b1;
      end
    end
  end

endmodule
